// File: rtl/uart_word_tx_if.sv
// Handshake bundle between the debug controller, the word serializer and the UART byte transmitter.
interface uart_word_tx_if #(
  parameter int NBITS      = 32,
  parameter int BYTE_WIDTH = 8
);
  logic [NBITS-1:0]      tx_Data;
  logic                  tx_start;
  logic                  tx_done;
  logic                  busy;
  logic [BYTE_WIDTH-1:0] byte_Data;
  logic                  byte_start;
  logic                  byte_done;

  modport slave (
    input  tx_Data, tx_start, byte_done,
    output tx_done, busy, byte_Data, byte_start
  );

  modport master (
    output tx_Data, tx_start, byte_done,
    input  tx_done, busy, byte_Data, byte_start
  );
endinterface

// File: rtl/uart_word_tx.sv
// Splits an NBITS word into BYTE_WIDTH-wide bytes and hands them LSB-first to a UART
// byte transmitter, one byte_start/byte_done handshake per byte.
module uart_word_tx #(
  parameter int NBITS      = 32,
  parameter int BYTE_WIDTH = 8
) (
  input  logic           clk,
  input  logic           reset,
  uart_word_tx_if.slave  bus
);
  localparam int NBYTES = NBITS / BYTE_WIDTH;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [NBITS-1:0] r_shift;
  logic [NBITS-1:0] w_shift_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // tx_start only matters in IDLE and byte_done only in WAIT; everywhere else they fall through.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (bus.tx_start) begin
          w_shift_nxt = bus.tx_Data;
          w_cnt_nxt   = '0;
          w_state_nxt = SEND;
        end
      end
      SEND: w_state_nxt = WAIT;
      WAIT: begin
        if (bus.byte_done) begin
          w_shift_nxt = r_shift >> BYTE_WIDTH;
          if (r_cnt == LAST_CNT) begin
            w_state_nxt = DONE;
          end else begin
            w_cnt_nxt   = r_cnt + 1'b1;
            w_state_nxt = SEND;
          end
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // All outputs come straight from registers or a decode of r_state.
  assign bus.byte_Data  = r_shift[BYTE_WIDTH-1:0];
  assign bus.byte_start = (r_state == SEND);
  assign bus.tx_done    = (r_state == DONE);
  assign bus.busy       = (r_state != IDLE);
endmodule

// File: doc/uart_word_tx.md
UART_WORD_TX -- requirements
Module: uart_word_tx

Interface
REQ-001 SHALL have parameter NBITS, default 32, the width of the word accepted from the debug controller.
REQ-002 SHALL have parameter BYTE_WIDTH, default 8, the width of one UART byte.
REQ-003 SHALL require NBITS to be an integer multiple of BYTE_WIDTH; NBYTES = NBITS/BYTE_WIDTH.
REQ-004 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-low reset (0 = reset, sampled on rising clk).
REQ-006 SHALL have port tx_Data, input, NBITS: word to transmit; sampled only on accept.
REQ-007 SHALL have port tx_start, input, 1 bit: request to send tx_Data.
REQ-008 SHALL have port tx_done, output, 1 bit: one-cycle pulse, whole word sent.
REQ-009 SHALL have port busy, output, 1 bit: high from accept until tx_done inclusive.
REQ-010 SHALL have port byte_Data, output, BYTE_WIDTH: byte presented to the UART transmitter.
REQ-011 SHALL have port byte_start, output, 1 bit: one-cycle pulse launching byte_Data.
REQ-012 SHALL have port byte_done, input, 1 bit: UART transmitter finished the current byte.

Function
REQ-013 SHALL implement FSM states IDLE, SEND, WAIT, DONE.
REQ-014 IDLE: if tx_start=1, SHALL on that edge:
- capture tx_Data into an NBITS shift register;
- clear the byte counter (width clog2(NBYTES), minimum 1);
- set busy=1;
- go to SEND.
REQ-015 SEND: SHALL assert byte_start=1 for exactly one cycle, with byte_Data = shift register bits [BYTE_WIDTH-1:0]; next state WAIT.
REQ-016 Byte order SHALL be LSB-first: byte 0 = tx_Data[7:0], last byte = tx_Data[NBITS-1:NBITS-8].
REQ-017 WAIT: SHALL hold byte_Data stable and byte_start=0 until byte_done=1.
REQ-018 On byte_done in WAIT:
- shift the register right by BYTE_WIDTH;
- if counter = NBYTES-1, go to DONE;
- otherwise increment the counter and go to SEND.
REQ-019 DONE: SHALL assert tx_done=1 for exactly one cycle, then return to IDLE with busy=0.
REQ-020 Latency SHALL be: tx_start accepted at edge k → byte_start high in cycle k+1; byte_done of last byte at edge m → tx_done high in cycle m+1.
REQ-021 tx_start SHALL be ignored in every state except IDLE; tx_Data changes after accept SHALL NOT affect the word in flight.
REQ-022 byte_done SHALL be ignored in every state except WAIT, including byte_done coincident with byte_start in SEND.
REQ-023 tx_start held high SHALL cause back-to-back words: the first IDLE cycle after DONE accepts a new word, so the minimum gap between tx_done and the next byte_start is 2 cycles.
REQ-024 No more than NBYTES byte_start pulses SHALL be issued per accepted word.
REQ-025 byte_Data SHALL be driven from a register; byte_start and tx_done SHALL be decoded from registered state only (no combinational input-to-output path).

Reset
REQ-026 With reset=0 at a rising clk edge, the block SHALL enter IDLE and set outputs to tx_done=0, busy=0, byte_start=0, byte_Data=0, with the shift register and counter at 0.
REQ-027 Reset asserted mid-word (SEND/WAIT/DONE) SHALL abandon the word: no further byte_start and no tx_done.
REQ-028 The first tx_start SHALL be accepted in the first cycle after reset returns to 1.

Verification
REQ-029 Basic word: tx_Data=32'h10001000, tx_start pulse, byte_done 3 cycles after each byte_start → bytes 00,10,00,10 in order; exactly 4 byte_start pulses; one tx_done; busy low after it.
REQ-030 Busy ignore: mid-word, tx_Data=32'hFFFFFFFF with tx_start=1 → current word bytes unchanged; no extra byte_start; after tx_done, new word accepted only if tx_start is still high.
REQ-031 Spurious done: byte_done=1 in IDLE and in the SEND cycle → no state change, no shift, no tx_done.
REQ-032 Back-to-back: tx_start held high with words 32'h00000045 then 32'h00000FFF → bytes 45,00,00,00,FF,0F,00,00; two tx_done pulses; 2-cycle gap per REQ-023.
REQ-033 Reset mid-word: reset=0 in WAIT after the 2nd byte → all outputs 0 next cycle; no tx_done; a fresh word 32'h7F after reset sends 7F,00,00,00 correctly.
REQ-034 Parameter check: NBITS=16 → exactly 2 bytes per word, LSB first, counter wraps correctly.
